// File: rtl/alu_interface_pkg.sv
// Shared ALU opcode codes and alu_interface FSM encoding.
// Imported by the ALU and by the serial-to-ALU bridge so both agree on the opcode map.
package alu_interface_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  function automatic logic is_valid_opcode(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_interface.sv
// Collects A, B, opcode bytes from the UART receiver, runs the ALU, sends the result; tx_start 2 cycles after opcode.
// No backpressure: bytes arriving while busy are dropped and flagged with o_overrun.
module alu_interface
  import alu_interface_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [NB_DATA-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic [NB_DATA-1:0]   o_first_operator,
  output logic [NB_DATA-1:0]   o_second_operator,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_error,
  output logic                 o_overrun
);

  state_t state_q;
  state_t state_d;
  logic   busy;
  logic   rx_byte_ok;

  // Whole byte must match: any set bit above the opcode field makes it invalid.
  assign rx_byte_ok = ((i_rx_data >> NB_OPCODE) == '0) &&
                      is_valid_opcode(OPCODE_W'(i_rx_data[NB_OPCODE-1:0]));

  assign busy   = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);
  assign o_busy = busy;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:  if (i_rx_done) state_d = WAIT_B;
      WAIT_B:  if (i_rx_done) state_d = WAIT_OP;
      WAIT_OP: if (i_rx_done) state_d = EXEC;
      EXEC:    state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_first_operator  <= '0;
      o_second_operator <= '0;
      o_opcode          <= '0;
      o_tx_data         <= '0;
      o_tx_start        <= 1'b0;
      o_error           <= 1'b0;
      o_overrun         <= 1'b0;
    end else begin
      o_tx_start <= (state_q == SEND);
      o_error    <= (state_q == WAIT_OP) && i_rx_done && !rx_byte_ok;
      o_overrun  <= busy && i_rx_done;

      if (state_q == WAIT_A && i_rx_done) begin
        o_first_operator <= i_rx_data;
      end
      if (state_q == WAIT_B && i_rx_done) begin
        o_second_operator <= i_rx_data;
      end
      if (state_q == WAIT_OP && i_rx_done) begin
        o_opcode <= i_rx_data[NB_OPCODE-1:0];
      end
      // o_error is high exactly during EXEC for a bad opcode byte, so it doubles as the zero-force.
      if (state_q == EXEC) begin
        o_tx_data <= o_error ? '0 : i_alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_interface.sv
// Bench for alu_interface: stub ALU on the operand ports, directed frames plus random frames vs. a byte-level model.
`timescale 1ns/1ps
module tb_alu_interface;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] a_op;
  logic [7:0] b_op;
  logic [5:0] opcode;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       error;
  logic       overrun;

  int vectors;
  int miscompares;

  alu_interface #(.NB_DATA(8), .NB_OPCODE(6)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_rx_data        (rx_data),
    .i_rx_done        (rx_done),
    .i_tx_done        (tx_done),
    .i_alu_result     (alu_result),
    .o_first_operator (a_op),
    .o_second_operator(b_op),
    .o_opcode         (opcode),
    .o_tx_data        (tx_data),
    .o_tx_start       (tx_start),
    .o_busy           (busy),
    .o_error          (error),
    .o_overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU; unknown codes give a non-zero pattern so the interface's zero-forcing is visible.
  always_comb begin
    alu_result = a_op ^ b_op ^ 8'hA5;
    case (opcode)
      6'b100000: alu_result = a_op + b_op;
      6'b100010: alu_result = a_op - b_op;
      6'b100100: alu_result = a_op & b_op;
      6'b100101: alu_result = a_op | b_op;
      6'b100110: alu_result = a_op ^ b_op;
      6'b000011: alu_result = 8'($signed(a_op) >>> b_op);
      6'b000010: alu_result = a_op >> b_op;
      6'b100111: alu_result = ~(a_op | b_op);
      default:   ;
    endcase
  end

  // Reference: expected transmitted byte for a full opcode byte (invalid -> error, 0 sent).
  function automatic logic [8:0] ref_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    logic [7:0] r;
    logic       bad;
    bad = 1'b0;
    r   = 8'h00;
    case (op)
      8'h20: r = a + b;
      8'h22: r = a - b;
      8'h24: r = a & b;
      8'h25: r = a | b;
      8'h26: r = a ^ b;
      8'h03: r = 8'($signed(a) >>> b);
      8'h02: r = a >> b;
      8'h27: r = ~(a | b);
      default: bad = 1'b1;
    endcase
    return {bad, r};
  endfunction

  // Called at a negedge; the following posedge samples the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int hold, input logic early_tx,
                           output int lat, output int starts, output int errs, output int ovrs,
                           output logic [7:0] txd, output logic busy_ok, output logic idle_after);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    lat = -1; starts = 0; errs = 0; ovrs = 0; txd = 8'h00; busy_ok = 1'b1;
    for (int k = 0; k < 4 + hold; k++) begin
      if (tx_start) begin
        if (lat < 0) begin
          lat = k;
          txd = tx_data;
        end
        starts++;
      end
      if (error) errs++;
      if (overrun) ovrs++;
      if (!busy) busy_ok = 1'b0;
      tx_done = early_tx && (k == 0);
      @(negedge clk);
      tx_done = 1'b0;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    idle_after = !busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    #12;
    vectors++;
    if ({a_op, b_op, opcode, tx_data, tx_start, busy, error, overrun} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got a=%h b=%h op=%h txd=%h st=%b busy=%b err=%b ovr=%b required all 0",
               a_op, b_op, opcode, tx_data, tx_start, busy, error, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0] tab [6][5];
    int lat, starts, errs, ovrs;
    logic [7:0] txd;
    logic busy_ok, idle_after;
    tab[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 8'h00};
    tab[1] = '{8'h03, 8'h05, 8'h22, 8'hFE, 8'h00};
    tab[2] = '{8'h80, 8'h02, 8'h03, 8'hE0, 8'h00};
    tab[3] = '{8'h80, 8'h02, 8'h02, 8'h20, 8'h00};
    tab[4] = '{8'h0F, 8'h01, 8'h3F, 8'h00, 8'h01};
    tab[5] = '{8'h0F, 8'h01, 8'hE0, 8'h00, 8'h01};
    for (int i = 0; i < 6; i++) begin
      run_frame(tab[i][0], tab[i][1], tab[i][2], i, 1'b0, lat, starts, errs, ovrs, txd, busy_ok, idle_after);
      vectors++;
      if (txd !== tab[i][3]) begin
        miscompares++;
        $display("FAIL directed%0d_tx_data: got %h required %h", i, txd, tab[i][3]);
      end
      vectors++;
      if (lat != 2 || starts != 1) begin
        miscompares++;
        $display("FAIL directed%0d_tx_start: latency %0d width %0d required 2 and 1", i, lat, starts);
      end
      vectors++;
      if (errs != int'(tab[i][4])) begin
        miscompares++;
        $display("FAIL directed%0d_error: got %0d pulses required %0d", i, errs, tab[i][4]);
      end
      vectors++;
      if (opcode !== tab[i][2][5:0] || a_op !== tab[i][0] || b_op !== tab[i][1]) begin
        miscompares++;
        $display("FAIL directed%0d_operands: got a=%h b=%h op=%h required a=%h b=%h op=%h",
                 i, a_op, b_op, opcode, tab[i][0], tab[i][1], tab[i][2][5:0]);
      end
      vectors++;
      if (!busy_ok || !idle_after || ovrs != 0) begin
        miscompares++;
        $display("FAIL directed%0d_busy: busy_held=%b idle_after=%b overruns=%0d required 1 1 0",
                 i, busy_ok, idle_after, ovrs);
      end
    end
  endtask

  task automatic test_overrun;
    int lat, starts, errs, ovrs;
    logic [7:0] txd;
    logic busy_ok, idle_after;
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h25);
    @(negedge clk); @(negedge clk);
    send_byte(8'hAA);
    vectors++;
    if (overrun !== 1'b1 || busy !== 1'b1 || a_op !== 8'h10 || b_op !== 8'h20 || opcode !== 6'h25) begin
      miscompares++;
      $display("FAIL overrun_pulse: got ovr=%b busy=%b a=%h b=%h op=%h required 1 1 10 20 25",
               overrun, busy, a_op, b_op, opcode);
    end
    @(negedge clk);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_width: got %b required 0", overrun);
    end
    tx_done = 1'b1; @(negedge clk); tx_done = 1'b0;
    run_frame(8'h01, 8'h01, 8'h20, 0, 1'b0, lat, starts, errs, ovrs, txd, busy_ok, idle_after);
    vectors++;
    if (txd !== 8'h02 || a_op !== 8'h01) begin
      miscompares++;
      $display("FAIL overrun_next_frame: got txd=%h a=%h required 02 01", txd, a_op);
    end
    // Byte arriving on the same edge as tx_done: return to idle but drop the byte.
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h26);
    @(negedge clk); @(negedge clk);
    rx_data = 8'h55; rx_done = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; tx_done = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || busy !== 1'b0 || a_op !== 8'h33) begin
      miscompares++;
      $display("FAIL coincide: got ovr=%b busy=%b a=%h required 1 0 33", overrun, busy, a_op);
    end
    run_frame(8'h06, 8'h03, 8'h24, 0, 1'b0, lat, starts, errs, ovrs, txd, busy_ok, idle_after);
    vectors++;
    if (txd !== 8'h02 || a_op !== 8'h06 || b_op !== 8'h03) begin
      miscompares++;
      $display("FAIL coincide_next_frame: got txd=%h a=%h b=%h required 02 06 03", txd, a_op, b_op);
    end
  endtask

  task automatic test_reset_midframe;
    int lat, starts, errs, ovrs;
    logic [7:0] txd;
    logic busy_ok, idle_after;
    send_byte(8'h11);
    vectors++;
    if (a_op !== 8'h11) begin
      miscompares++;
      $display("FAIL midframe_capture: got a=%h required 11", a_op);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_op, b_op, opcode, tx_data, tx_start, busy, error, overrun} !== 34'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: got a=%h b=%h op=%h txd=%h st=%b busy=%b err=%b ovr=%b required all 0",
               a_op, b_op, opcode, tx_data, tx_start, busy, error, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h02, 8'h02, 8'h24, 0, 1'b0, lat, starts, errs, ovrs, txd, busy_ok, idle_after);
    vectors++;
    if (txd !== 8'h02 || a_op !== 8'h02 || lat != 2) begin
      miscompares++;
      $display("FAIL after_reset_frame: got txd=%h a=%h lat=%0d required 02 02 2", txd, a_op, lat);
    end
    send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_data !== 8'h00 || busy !== 1'b0 || a_op !== 8'h00) begin
      miscompares++;
      $display("FAIL busy_reset: got txd=%h busy=%b a=%h required 00 0 00", tx_data, busy, a_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] ops [8];
    logic [7:0] a, b, op, txd;
    logic [8:0] exp;
    int lat, starts, errs, ovrs;
    logic busy_ok, idle_after, early;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 7)] : 8'($urandom);
      early = 1'($urandom_range(0, 1));
      exp = ref_frame(a, b, op);
      run_frame(a, b, op, int'($urandom_range(0, 3)), early, lat, starts, errs, ovrs, txd, busy_ok, idle_after);
      vectors++;
      if (txd !== exp[7:0] || errs != int'(exp[8]) || lat != 2 || starts != 1 ||
          !busy_ok || !idle_after || ovrs != 0 || opcode !== op[5:0] || a_op !== a || b_op !== b) begin
        miscompares++;
        $display("FAIL random%0d a=%h b=%h op=%h: got txd=%h err=%0d lat=%0d st=%0d busy=%b idle=%b ovr=%0d required txd=%h err=%0d lat=2 st=1 busy=1 idle=1 ovr=0",
                 i, a, b, op, txd, errs, lat, starts, busy_ok, idle_after, ovrs, exp[7:0], exp[8]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_interface.md
ALU_INTERFACE -- requirements
Module: alu_interface

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port SHALL be named i_clock and the reset port i_reset_n.
REQ-002 Parameters SHALL be:
- NB_DATA, default 8, operand, result and serial byte width.
- NB_OPCODE, default 6, ALU opcode width.
REQ-003 Ports SHALL be, clock and reset first:
- i_clock  in  1  system clock.
- i_reset_n  in  1  async active-low reset.
- i_rx_data  in  NB_DATA  byte from the serial receiver.
- i_rx_done  in  1  one-cycle pulse; i_rx_data valid.
- i_tx_done  in  1  one-cycle pulse; serial transmitter finished its byte.
- i_alu_result  in  NB_DATA  combinational ALU result.
- o_first_operator  out  NB_DATA  registered operand A to ALU.
- o_second_operator  out  NB_DATA  registered operand B to ALU.
- o_opcode  out  NB_OPCODE  registered opcode to ALU.
- o_tx_data  out  NB_DATA  result byte to the transmitter.
- o_tx_start  out  1  one-cycle pulse; start transmission.
- o_busy  out  1  high from the opcode capture until i_tx_done.
- o_error  out  1  one-cycle pulse; invalid opcode byte.
- o_overrun  out  1  one-cycle pulse; byte dropped while busy.

Function
REQ-004 The FSM SHALL have the states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND and WAIT_TX.
REQ-005 WAIT_A SHALL latch i_rx_data into o_first_operator on i_rx_done and go to WAIT_B.
REQ-006 WAIT_B SHALL latch i_rx_data into o_second_operator on i_rx_done and go to WAIT_OP.
REQ-007 WAIT_OP SHALL latch i_rx_data[NB_OPCODE-1:0] into o_opcode on i_rx_done and go to EXEC.
REQ-008 EXEC SHALL last exactly one cycle and register i_alu_result into o_tx_data, then go to SEND.
REQ-009 SEND SHALL assert o_tx_start for exactly one cycle, then go to WAIT_TX.
REQ-010 WAIT_TX SHALL hold until i_tx_done, then return to WAIT_A.
REQ-011 o_tx_start SHALL rise exactly 2 cycles after the clock edge that samples the opcode i_rx_done.
REQ-012 The opcode byte SHALL be valid only if its upper NB_DATA-NB_OPCODE bits are zero and its low bits are one of the following:
- ADD 100000, SUB 100010, AND 100100, OR 100101;
- XOR 100110, SRA 000011, SRL 000010, NOR 100111.
REQ-013 For an invalid opcode byte, o_error SHALL pulse in EXEC and o_tx_data SHALL be forced to 0; the frame SHALL still be transmitted.
REQ-014 An i_rx_done in EXEC, SEND or WAIT_TX SHALL be discarded and pulse o_overrun in the following cycle; operands and opcode SHALL be unchanged.
REQ-015 If i_rx_done and i_tx_done coincide in WAIT_TX, the block SHALL return to WAIT_A, discard the byte and pulse o_overrun.
REQ-016 An i_tx_done outside WAIT_TX SHALL be ignored.
REQ-017 o_first_operator, o_second_operator and o_opcode SHALL hold their values until overwritten by the next frame.
REQ-018 o_busy SHALL be high in EXEC, SEND and WAIT_TX and low otherwise.

Reset
REQ-019 On assertion of i_reset_n, regardless of the clock and at any state mid-frame, the FSM SHALL go to WAIT_A and all outputs SHALL be 0.
REQ-020 Partially received frames SHALL be discarded on reset; the first byte after deassertion SHALL be treated as operand A.

Structure
REQ-021 The opcode localparams and the FSM state encoding SHALL live in a shared package used by both the ALU and this block.
REQ-022 The block SHALL contain no sub-module; the ALU and the serial receiver/transmitter SHALL be instantiated and connected by the parent top level.

Verification
REQ-023 The bench SHALL cover at least these scenarios:
- Bytes 0x05, 0x03, 0x20 -> o_opcode=100000, o_tx_data=0x08, o_tx_start 2 cycles after the third rx_done, o_busy until tx_done.
- Bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE.
- Bytes 0x80, 0x02, 0x03 (SRA) -> o_tx_data=0xE0.
- Bytes 0x80, 0x02, 0x02 (SRL) -> o_tx_data=0x20.
- Bytes 0x0F, 0x01, 0x3F -> o_error pulse, o_tx_data=0x00, frame still sent.
- Byte 0xAA during WAIT_TX -> o_overrun pulse, operands unchanged; next frame 0x01, 0x01, 0x20 -> 0x02.
- Reset after operand A=0x11 -> all outputs 0, state WAIT_A; then 0x02, 0x02, 0x24 -> 0x02.
